// File: rtl/mem_stage.sv
// Memory stage: load/store handshake FSM, MEM/WB pipeline register and an access watchdog.
// Optional feature macro MEM_ALIGN_CHECK_EN: odd-address accesses fault instead of issuing.
module mem_stage #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] data_exe_in,
  input  logic [15:0] PC_Next_in,
  input  logic [15:0] extend_in,
  input  logic [1:0]  WB_sel_in,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [15:0] dm_rdata,
  output logic        wb_valid,
  output logic [15:0] data_mem,
  output logic [15:0] data_exe,
  output logic [15:0] PC_Next,
  output logic [15:0] extend,
  output logic [1:0]  WB_sel,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ERR  = 2'b10
  } state_t;

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 32'd1);

  state_t      state_r, state_next_s;
  logic [7:0]  cnt_r, cnt_next_s;
  logic        access_s, illegal_s, misalign_s;
  logic        stall_s, accept_s, wb_load_s;
  logic [15:0] addr_lat_s, data_mem_next_s;

  logic        dm_req_r, dm_we_r, wb_valid_r, err_r;
  logic [15:0] dm_addr_r, dm_wdata_r, data_mem_r, data_exe_r, pc_next_r, extend_r;
  logic [1:0]  wb_sel_r;

  assign access_s  = in_valid & (mem_read | mem_write);
  assign illegal_s = mem_read & mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = addr[0];
  assign addr_lat_s = {addr[15:1], 1'b0};
`else
  assign misalign_s = 1'b0;
  assign addr_lat_s = addr;
`endif

  // Next-state, stall and MEM/WB load decisions.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    stall_s         = 1'b0;
    accept_s        = 1'b0;
    wb_load_s       = 1'b0;
    data_mem_next_s = 16'h0000;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          stall_s = 1'b1;
          if (illegal_s | misalign_s) begin
            state_next_s = ERR;
          end else begin
            state_next_s = BUSY;
            accept_s     = 1'b1;
            cnt_next_s   = 8'd0;
          end
        end else begin
          wb_load_s = in_valid;
        end
      end
      BUSY: begin
        if (dm_ready) begin
          state_next_s    = IDLE;
          wb_load_s       = 1'b1;
          cnt_next_s      = 8'd0;
          data_mem_next_s = dm_we_r ? 16'h0000 : dm_rdata;
        end else begin
          stall_s    = 1'b1;
          cnt_next_s = cnt_r + 8'd1;
          // Watchdog: the WAIT_LIMIT-th idle BUSY cycle is the last one tolerated.
          if (cnt_r == LIMIT_M1) begin
            state_next_s = ERR;
          end else begin
            state_next_s = BUSY;
          end
        end
      end
      ERR: begin
        stall_s      = 1'b1;
        state_next_s = ERR;
      end
      default: begin
        stall_s      = 1'b1;
        state_next_s = ERR;
      end
    endcase
  end

  // State, request interface and MEM/WB pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      dm_req_r   <= 1'b0;
      dm_we_r    <= 1'b0;
      dm_addr_r  <= 16'h0000;
      dm_wdata_r <= 16'h0000;
      err_r      <= 1'b0;
      wb_valid_r <= 1'b0;
      data_mem_r <= 16'h0000;
      data_exe_r <= 16'h0000;
      pc_next_r  <= 16'h0000;
      extend_r   <= 16'h0000;
      wb_sel_r   <= 2'b00;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      dm_req_r   <= (state_next_s == BUSY);
      err_r      <= (state_next_s == ERR);
      wb_valid_r <= wb_load_s;
      // Request fields are captured only at accept so they stay stable through BUSY.
      if (accept_s) begin
        dm_we_r    <= mem_write;
        dm_addr_r  <= addr_lat_s;
        dm_wdata_r <= wdata;
      end else begin
        dm_we_r    <= dm_we_r;
        dm_addr_r  <= dm_addr_r;
        dm_wdata_r <= dm_wdata_r;
      end
      if (wb_load_s) begin
        data_mem_r <= data_mem_next_s;
        data_exe_r <= data_exe_in;
        pc_next_r  <= PC_Next_in;
        extend_r   <= extend_in;
        wb_sel_r   <= WB_sel_in;
      end else begin
        data_mem_r <= data_mem_r;
        data_exe_r <= data_exe_r;
        pc_next_r  <= pc_next_r;
        extend_r   <= extend_r;
        wb_sel_r   <= wb_sel_r;
      end
    end
  end

  assign stall    = stall_s;
  assign dm_req   = dm_req_r;
  assign dm_we    = dm_we_r;
  assign dm_addr  = dm_addr_r;
  assign dm_wdata = dm_wdata_r;
  assign err      = err_r;
  assign wb_valid = wb_valid_r;
  assign data_mem = data_mem_r;
  assign data_exe = data_exe_r;
  assign PC_Next  = pc_next_r;
  assign extend   = extend_r;
  assign WB_sel   = wb_sel_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with WAIT_LIMIT = 4; covers handshake, watchdog, reset and alignment.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_read, mem_write;
  logic [15:0] addr, wdata, data_exe_in, PC_Next_in, extend_in;
  logic [1:0]  WB_sel_in;
  logic        stall, dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata;
  logic        dm_ready;
  logic [15:0] dm_rdata;
  logic        wb_valid;
  logic [15:0] data_mem, data_exe, PC_Next, extend;
  logic [1:0]  WB_sel;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .data_exe_in(data_exe_in), .PC_Next_in(PC_Next_in),
    .extend_in(extend_in), .WB_sel_in(WB_sel_in), .stall(stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
    .dm_rdata(dm_rdata), .wb_valid(wb_valid), .data_mem(data_mem), .data_exe(data_exe),
    .PC_Next(PC_Next), .extend(extend), .WB_sel(WB_sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    in_valid    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr        = 16'h0000;
    wdata       = 16'h0000;
    data_exe_in = 16'h0000;
    PC_Next_in  = 16'h0000;
    extend_in   = 16'h0000;
    WB_sel_in   = 2'b00;
    dm_ready    = 1'b0;
    dm_rdata    = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    do_reset();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    total++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin bad++; $display("FAIL reset_req_we got=%0h%0h exp=00", dm_req, dm_we); end
    total++; if (dm_addr !== 16'h0000 || dm_wdata !== 16'h0000) begin bad++; $display("FAIL reset_addr_wdata got=%h/%h exp=0000/0000", dm_addr, dm_wdata); end
    total++; if (wb_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_valid_err got=%0h%0h exp=00", wb_valid, err); end
    total++; if ({data_mem, data_exe, PC_Next, extend, WB_sel} !== 66'h0) begin bad++; $display("FAIL reset_wb_fields got=%h exp=0", {data_mem, data_exe, PC_Next, extend, WB_sel}); end
  endtask

  task automatic test_nonmem();
    in_valid = 1'b1; data_exe_in = 16'h1234; WB_sel_in = 2'b01;
    PC_Next_in = 16'h0102; extend_in = 16'h0F0F;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL nonmem_stall got=%0h exp=0", stall); end
    step();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL nonmem_valid got=%0h exp=1", wb_valid); end
    total++; if (data_exe !== 16'h1234 || data_mem !== 16'h0000) begin bad++; $display("FAIL nonmem_data got=%h/%h exp=1234/0000", data_exe, data_mem); end
    total++; if (WB_sel !== 2'b01 || PC_Next !== 16'h0102 || extend !== 16'h0F0F) begin bad++; $display("FAIL nonmem_fields got=%0h/%h/%h exp=1/0102/0f0f", WB_sel, PC_Next, extend); end
    total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL nonmem_req got=%0h exp=0", dm_req); end
    quiet_inputs();
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL nonmem_idle_valid got=%0h exp=0", wb_valid); end
  endtask

  task automatic test_load();
    in_valid = 1'b1; mem_read = 1'b1; addr = 16'h0040; data_exe_in = 16'h0040;
    WB_sel_in = 2'b10; PC_Next_in = 16'h0200;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_accept_stall got=%0h exp=1", stall); end
    for (int c = 1; c <= 2; c++) begin
      step();
      total++; if (stall !== 1'b1 || dm_req !== 1'b1) begin bad++; $display("FAIL load_busy%0d_stall_req got=%0h%0h exp=11", c, stall, dm_req); end
      total++; if (dm_addr !== 16'h0040 || dm_we !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL load_busy%0d_addr_we got=%h/%0h/%0h exp=0040/0/0", c, dm_addr, dm_we, wb_valid); end
    end
    step();
    dm_ready = 1'b1; dm_rdata = 16'hBEEF;
    #1;
    total++; if (stall !== 1'b0 || dm_addr !== 16'h0040 || dm_req !== 1'b1) begin bad++; $display("FAIL load_busy3 got=%0h/%h/%0h exp=0/0040/1", stall, dm_addr, dm_req); end
    step();
    total++; if (wb_valid !== 1'b1 || data_mem !== 16'hBEEF) begin bad++; $display("FAIL load_wb got=%0h/%h exp=1/beef", wb_valid, data_mem); end
    total++; if (data_exe !== 16'h0040 || WB_sel !== 2'b10 || PC_Next !== 16'h0200) begin bad++; $display("FAIL load_wb_fields got=%h/%0h/%h exp=0040/2/0200", data_exe, WB_sel, PC_Next); end
    total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%0h exp=0", dm_req); end
    quiet_inputs();
    step();
  endtask

  task automatic test_store_and_back_to_back();
    in_valid = 1'b1; mem_write = 1'b1; addr = 16'h0010; wdata = 16'h00AA; data_exe_in = 16'h0010;
    step();
    total++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 16'h00AA || dm_addr !== 16'h0010) begin bad++; $display("FAIL store_busy got=%0h/%0h/%h/%h exp=1/1/00aa/0010", dm_req, dm_we, dm_wdata, dm_addr); end
    dm_ready = 1'b1; dm_rdata = 16'h5555;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL store_done_stall got=%0h exp=0", stall); end
    step();
    total++; if (wb_valid !== 1'b1 || data_mem !== 16'h0000 || data_exe !== 16'h0010) begin bad++; $display("FAIL store_wb got=%0h/%h/%h exp=1/0000/0010", wb_valid, data_mem, data_exe); end
    // next access presented right after completion
    dm_ready = 1'b0; mem_write = 1'b0; mem_read = 1'b1; addr = 16'h0022; data_exe_in = 16'h0022;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_accept_stall got=%0h exp=1", stall); end
    step();
    total++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 16'h0022 || wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%0h/%0h/%h/%0h exp=1/0/0022/0", dm_req, dm_we, dm_addr, wb_valid); end
    dm_ready = 1'b1; dm_rdata = 16'h1357;
    step();
    total++; if (wb_valid !== 1'b1 || data_mem !== 16'h1357 || data_exe !== 16'h0022) begin bad++; $display("FAIL b2b_wb got=%0h/%h/%h exp=1/1357/0022", wb_valid, data_mem, data_exe); end
    quiet_inputs();
    step();
  endtask

  task automatic test_wait_limit();
    // ready on the 4th BUSY cycle still completes
    in_valid = 1'b1; mem_read = 1'b1; addr = 16'h0080;
    for (int c = 0; c < 4; c++) step();
    dm_ready = 1'b1; dm_rdata = 16'hCAFE;
    step();
    total++; if (wb_valid !== 1'b1 || data_mem !== 16'hCAFE || err !== 1'b0) begin bad++; $display("FAIL limit_edge got=%0h/%h/%0h exp=1/cafe/0", wb_valid, data_mem, err); end
    // no ready for 4 BUSY cycles
    dm_ready = 1'b0; addr = 16'h0090;
    for (int c = 0; c < 4; c++) step();
    total++; if (err !== 1'b0 || stall !== 1'b1 || dm_req !== 1'b1) begin bad++; $display("FAIL limit_busy4 got=%0h/%0h/%0h exp=0/1/1", err, stall, dm_req); end
    step();
    quiet_inputs();
    #1;
    total++; if (err !== 1'b1 || dm_req !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL limit_err got=%0h/%0h/%0h/%0h exp=1/0/1/0", err, dm_req, stall, wb_valid); end
    dm_ready = 1'b1;
    step();
    step();
    total++; if (err !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL limit_sticky got=%0h/%0h exp=1/1", err, stall); end
    dm_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (err !== 1'b0 || stall !== 1'b0 || dm_req !== 1'b0 || dm_addr !== 16'h0000 || data_mem !== 16'h0000) begin bad++; $display("FAIL limit_rst got=%0h/%0h/%0h/%h/%h exp=0/0/0/0000/0000", err, stall, dm_req, dm_addr, data_mem); end
  endtask

  task automatic test_reset_mid_busy();
    in_valid = 1'b1; mem_read = 1'b1; addr = 16'h0030;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    quiet_inputs();
    total++; if (dm_req !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL midrst_req got=%0h/%0h exp=0/0", dm_req, wb_valid); end
    dm_ready = 1'b1; dm_rdata = 16'hDEAD;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%0h exp=0", stall); end
    step();
    dm_ready = 1'b0;
    total++; if (wb_valid !== 1'b0 || data_mem !== 16'h0000 || err !== 1'b0) begin bad++; $display("FAIL midrst_ignore got=%0h/%h/%0h exp=0/0000/0", wb_valid, data_mem, err); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; addr = 16'h0050;
    step();
    quiet_inputs();
    total++; if (err !== 1'b1 || dm_req !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL illegal got=%0h/%0h/%0h exp=1/0/1", err, dm_req, stall); end
    do_reset();
  endtask

  task automatic test_align();
    in_valid = 1'b1; mem_read = 1'b1; addr = 16'h0003;
    step();
`ifdef MEM_ALIGN_CHECK_EN
    quiet_inputs();
    total++; if (dm_req !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL align_fault got=%0h/%0h exp=0/1", dm_req, err); end
    do_reset();
`else
    total++; if (dm_req !== 1'b1 || dm_addr !== 16'h0003 || err !== 1'b0) begin bad++; $display("FAIL align_pass got=%0h/%h/%0h exp=1/0003/0", dm_req, dm_addr, err); end
    dm_ready = 1'b1; dm_rdata = 16'h0707;
    step();
    quiet_inputs();
    total++; if (wb_valid !== 1'b1 || data_mem !== 16'h0707) begin bad++; $display("FAIL align_wb got=%0h/%h exp=1/0707", wb_valid, data_mem); end
    step();
`endif
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    test_reset();
    test_nonmem();
    test_load();
    test_store_and_back_to_back();
    test_wait_limit();
    test_reset_mid_busy();
    test_illegal();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, sitting between execute and write-back. It issues loads and stores to the data memory through a request/ready handshake and stalls the upstream pipeline while an access is outstanding. It also registers the MEM/WB pipeline fields (mem data, ALU result, PC_Next, extend, WB_sel) that feed the write-back mux. A watchdog flags a memory that never answers.

## Interface
Parameters:
- WAIT_LIMIT, 15: maximum number of BUSY cycles allowed per access; legal range 1..255.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents a valid instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- addr  in  16  effective address (ALU result).
- wdata  in  16  store data.
- data_exe_in  in  16  ALU result, passed to WB.
- PC_Next_in  in  16  next PC, passed to WB.
- extend_in  in  16  extended immediate, passed to WB.
- WB_sel_in  in  2  write-back select, passed to WB.
- stall  out  1  freeze fetch/decode/execute this cycle (combinational).
- dm_req  out  1  memory request, registered.
- dm_we  out  1  1 = store, 0 = load, registered.
- dm_addr  out  16  latched address.
- dm_wdata  out  16  latched store data.
- dm_ready  in  1  memory completes the current request this cycle.
- dm_rdata  in  16  load data; valid when dm_ready = 1.
- wb_valid  out  1  MEM/WB register holds a valid instruction.
- data_mem  out  16  registered load data (0 for non-loads).
- data_exe  out  16  registered ALU result.
- PC_Next  out  16  registered next PC.
- extend  out  16  registered immediate.
- WB_sel  out  2  registered write-back select.
- err  out  1  sticky fault flag.

## Operation
- Defined terms:
  - access = in_valid & (mem_read | mem_write).
  - illegal = mem_read & mem_write.
- FSM states: IDLE, BUSY, ERR.
- IDLE, in_valid and no access:
  - MEM/WB register loads the input fields with data_mem = 0 and wb_valid = 1.
  - No stall.
- IDLE, access and not illegal:
  - stall = 1.
  - Latch addr, wdata and dm_we = mem_write.
  - Next state BUSY, with dm_req = 1 and wait counter = 0.
  - wb_valid = 0 next cycle (bubble).
- IDLE, access and illegal: next state ERR.
- IDLE, in_valid = 0: wb_valid = 0 next cycle.
- BUSY, dm_ready = 1:
  - stall = 0.
  - MEM/WB register loads the current input fields, still held by upstream because of the stall.
  - data_mem = dm_rdata for loads, 0 for stores; wb_valid = 1.
  - dm_req drops; next state IDLE.
- BUSY, dm_ready = 0:
  - stall = 1; counter increments (8-bit).
  - If counter == WAIT_LIMIT-1, next state is ERR.
- ERR:
  - err = 1, stall = 1, dm_req = 0, wb_valid = 0.
  - Exit only by rst.
- dm_addr, dm_wdata and dm_we are held stable for the whole of BUSY.
- dm_ready outside BUSY is ignored.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - dm_req, dm_we, wb_valid, err = 0.
  - dm_addr, dm_wdata, data_mem, data_exe, PC_Next, extend = 0; WB_sel = 0.
- stall is combinational:
  - state==ERR
  - | (state==IDLE & access)
  - | (state==BUSY & !dm_ready).
- Latency:
  - Non-memory instruction: 1 cycle to WB.
  - Memory access with ready on the k-th BUSY cycle: k+1 cycles to WB; minimum 2.
- Wait limit: ready on the WAIT_LIMIT-th BUSY cycle still completes normally. No ready after WAIT_LIMIT BUSY cycles puts the FSM in ERR on the following edge.
- Reset mid-BUSY: dm_req is 0 the next cycle, the access is abandoned, and a later dm_ready is ignored.
- Back-to-back accesses: the cycle after completion returns to IDLE and may accept the next access immediately, giving one non-stall cycle between accesses.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - An access with addr[0] = 1 goes IDLE→ERR instead of BUSY, and no request is issued.
  - dm_addr is always even.
- MEM_ALIGN_CHECK_EN undefined: odd addresses are forwarded unchanged to dm_addr.

## Test plan
- Non-memory op, data_exe_in = 0x1234 and WB_sel_in = 2'b01 → next cycle wb_valid = 1, data_exe = 0x1234, data_mem = 0, stall never 1.
- Load from 0x0040, dm_ready on the 3rd BUSY cycle with dm_rdata = 0xBEEF → stall high for 3 cycles, dm_addr = 0x0040 and dm_we = 0 throughout, data_mem = 0xBEEF and wb_valid = 1 four cycles after accept.
- Store 0x00AA to 0x0010 with immediate ready → dm_we = 1 and dm_wdata = 0x00AA in the single BUSY cycle, data_mem = 0, total latency 2.
- WAIT_LIMIT = 4 and dm_ready held low → after 4 BUSY cycles err = 1, dm_req = 0 and stall = 1 until rst; rst clears everything to the reset values.
- rst asserted on the 2nd BUSY cycle, then dm_ready pulsed → state IDLE, no wb_valid, data_mem = 0.
- With MEM_ALIGN_CHECK_EN, load from 0x0003 → dm_req stays 0 and err = 1 the next cycle. Without it, the request is issued with dm_addr = 0x0003.
